adc_serial_responder: RTL
=========================

Name: adc_serial_responder

Overview:
- Emulates a 12-bit serial ADC (chip-select, serial clock, serial data out) on the slave side of the ADC link, so the ADC controllers can be checked in loopback on the board without the real converters.
- Drives the ADC controller's sync/sclk into its inputs and returns its sdo to the controller's SDO input.
- Sample values come from an internal pattern generator (ramp, constant or LFSR).
- Exposes per-frame status so the host can compare what was sent against what the controller captured.

Parameters:
DATA_W, 12, sample width in bits.
LEAD_ZEROS, 4, leading zero bits before the sample MSB; frame length is LEAD_ZEROS+DATA_W = 16.
SYNC_STAGES, 2, flip-flop stages in the input synchronisers for sync and sclk.

Ports:
clk  in  1  system clock.
rst  in  1  reset. Asynchronous, active-high.
sync  in  1  chip-select from the ADC controller, active-low, asynchronous to clk.
sclk  in  1  serial clock from the ADC controller, asynchronous to clk.
sdo  out  1  serial data to the controller.
sdo_oe  out  1  high while a frame is active (pad enable).
mode  in  2  pattern select: 0 ramp, 1 constant, 2 LFSR, 3 treated as constant.
const_val  in  DATA_W  value used in constant mode.
ramp_step  in  DATA_W  ramp increment per completed frame.
frame_done  out  1  one-cycle pulse when a full frame has been shifted.
frame_err  out  1  one-cycle pulse when sync rises before the frame completes.
frame_cnt  out  16  completed-frame counter, wraps 0xFFFF -> 0.
last_word  out  DATA_W  sample sent in the last completed frame.

Behaviour:
- Reset values: sdo=0, sdo_oe=0, frame_done=0, frame_err=0, frame_cnt=0, last_word=0, ramp=0, lfsr=12'h001, state IDLE.
- Reset asserted mid-frame aborts the frame immediately, with no frame_err pulse.
- Input handling: sync and sclk each pass through SYNC_STAGES flops before edge detection, then one registered edge-detect stage.
- Latency from pin edge to sdo update is SYNC_STAGES+1 clk cycles.
- Supported sclk: high and low phases each at least SYNC_STAGES+3 clk cycles. Faster sclk is out of spec.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - sclk edges are ignored.
  - On a sync falling edge: latch sample S = pattern(mode) into a shift register holding {LEAD_ZEROS zeros, S}. Then set sdo = shift MSB (0), sdo_oe=1, bit counter=0, go to SHIFT.
- SHIFT:
  - Each sclk falling edge shifts left one bit, sdo = new MSB, counter +1.
  - The host samples on sclk rising edges.
  - On the falling edge when counter reaches 16 (i.e. after the LSB has been presented for a full rising edge): sdo=0, frame_done pulse, last_word=S, frame_cnt+1, advance the pattern generator, go to DONE.
- DONE: sdo=0, sdo_oe stays 1. On a sync rising edge: sdo_oe=0, go to IDLE.
- Abort: a sync rising edge in SHIFT produces a frame_err pulse, sdo=0, sdo_oe=0, go to IDLE. In an aborted frame the pattern does not advance, and frame_cnt and last_word are unchanged.
- Simultaneous sync rise and sclk fall in the same cycle: sync wins. Treated as abort if in SHIFT; the shift is discarded.
- sclk rising edges never change state.
- Patterns, all arithmetic mod 2^DATA_W:
  - Ramp: the current value is sent; after each completed frame, ramp += ramp_step (wraps, 4095+1 -> 0).
  - Constant: const_val, sampled at the sync falling edge.
  - LFSR: Fibonacci, polynomial x^12+x^6+x^4+x+1, shifting left, feedback bit = lfsr[11]^lfsr[5]^lfsr[3]^lfsr[0] into bit 0. It advances one step per completed frame and never reaches zero.
- Ramp and LFSR state advance only on completed frames and only in their own mode. Both retain their values when mode changes.
- A mode or const_val change mid-frame affects only the next frame.

Decomposition:
- Shared package (adc_emu_pkg): DATA_W, LEAD_ZEROS, frame length, mode encodings (MODE_RAMP, MODE_CONST, MODE_LFSR), LFSR seed and tap mask, state encoding.
- One sub-module, edge_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated twice (sync, sclk).

Test Plan:
- Constant mode, const_val=12'hA5C, one 16-clock frame -> sdo bits 0000_1010_0101_1100 on rising edges; frame_done=1 pulse; last_word=12'hA5C; frame_cnt=1.
- Ramp mode, ramp_step=12'h001, 4 frames starting after reset -> words 0,1,2,3; frame_cnt=4. Then preset via 4095 frames with step 1 -> word 12'hFFF followed by 12'h000 (wrap).
- LFSR mode, 3 frames after reset -> words 12'h001, then the two successive LFSR states computed by the model; never 0 over 4095 frames (full period returns to 12'h001).
- Abort: sync rises after 7 sclk falls -> frame_err pulse, sdo_oe=0, frame_cnt unchanged. Next frame sends the same ramp value as the aborted one.
- Simultaneous sync rise and the 16th sclk fall in the same clk cycle -> frame_err=1, frame_done=0, frame_cnt unchanged.
- rst asserted at bit 9 of a frame -> sdo=0, sdo_oe=0 and all counters 0 within the same cycle. A following full frame in ramp mode sends 12'h000.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// Shared constants for the ADC slave-side emulator: frame geometry,
// pattern-mode encodings, LFSR seed/taps and the responder state encoding.
// No logic; imported by the responder top and its synchroniser.
package adc_emu_pkg;

    localparam int DATA_W      = 12;
    localparam int LEAD_ZEROS  = 4;
    localparam int FRAME_LEN   = LEAD_ZEROS + DATA_W;
    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    // x^12+x^6+x^4+x+1: feedback taps at bits 11, 5, 3 and 0.
    localparam logic [DATA_W-1:0] LFSR_SEED = 12'h001;
    localparam logic [DATA_W-1:0] LFSR_TAPS = 12'h829;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } respState_t;

endpackage

// File: rtl/edge_sync.sv
// Purpose: synchronise an asynchronous pin into clk and flag its edges.
// Latency: pin edge -> rise/fall pulse after STAGES clk edges, pulse lasts one cycle.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), din (async pin), rise/fall (one-cycle pulses).
module edge_sync #(
    parameter int   STAGES  = 2,     // must be >= 2
    parameter logic RST_VAL = 1'b0   // idle level of the pin, avoids a false edge after reset
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] syncReg;
    logic              prevReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncReg <= {STAGES{RST_VAL}};
            prevReg <= RST_VAL;
        end else begin
            syncReg <= {syncReg[STAGES-2:0], din};
            prevReg <= syncReg[STAGES-1];
        end
    end

    // prevReg is the registered edge-detect stage; the pulses are valid the
    // cycle before it catches up, so the consumer's register lands at STAGES+1.
    assign rise = syncReg[STAGES-1] & ~prevReg;
    assign fall = ~syncReg[STAGES-1] & prevReg;

endmodule

// File: rtl/adc_serial_responder.sv
// Purpose: slave-side emulation of a 12-bit serial ADC (sync/sclk in, sdo out) with pattern source.
// Latency: pin edge on sync/sclk -> sdo/sdo_oe update after SYNC_STAGES+1 clk cycles.
// Backpressure: none; the controller paces frames, sclk phases must be >= SYNC_STAGES+3 clk.
// Ports: clk, rst; sync, sclk (async from controller); sdo, sdo_oe (to controller);
//        mode, const_val, ramp_step (pattern config); frame_done, frame_err, frame_cnt, last_word (status).
module adc_serial_responder import adc_emu_pkg::*; #(
    parameter int DATA_W      = adc_emu_pkg::DATA_W,
    parameter int LEAD_ZEROS  = adc_emu_pkg::LEAD_ZEROS,
    parameter int SYNC_STAGES = adc_emu_pkg::SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic              sclk,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [DATA_W-1:0] ramp_step,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt,
    output logic [DATA_W-1:0] last_word
);

    localparam int FRAME = LEAD_ZEROS + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);

    logic syncRise, syncFall, sclkFall;
    // sclk rising edges never change state, so that pulse is left unconsumed.
    logic unusedSclkRise;

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) uSyncEdge (
        .clk  (clk),
        .rst  (rst),
        .din  (sync),
        .rise (syncRise),
        .fall (syncFall)
    );

    edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) uSclkEdge (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (unusedSclkRise),
        .fall (sclkFall)
    );

    respState_t        state, stateNext;
    logic [FRAME-1:0]  shiftReg, shiftNext;
    logic [CNT_W-1:0]  bitCnt, cntNext;
    logic [DATA_W-1:0] sampleReg, sampleNext;
    logic [1:0]        frameMode, frameModeNext;
    logic [DATA_W-1:0] rampReg, rampNext;
    logic [DATA_W-1:0] lfsrReg, lfsrNext;
    logic              sdoNext, oeNext, doneNext, errNext;
    logic [15:0]       frameCntNext;
    logic [DATA_W-1:0] lastWordNext;
    logic [DATA_W-1:0] pattern;
    logic [FRAME-1:0]  frameInit;

    // Mode 3 falls through to constant.
    always_comb begin
        pattern = const_val;
        case (mode)
            MODE_RAMP: pattern = rampReg;
            MODE_LFSR: pattern = lfsrReg;
            default:   pattern = const_val;
        endcase
    end

    assign frameInit = {{LEAD_ZEROS{1'b0}}, pattern};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shiftReg   <= '0;
            bitCnt     <= '0;
            sampleReg  <= '0;
            frameMode  <= MODE_RAMP;
            rampReg    <= '0;
            lfsrReg    <= LFSR_SEED;
            sdo        <= 1'b0;
            sdo_oe     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            last_word  <= '0;
        end else begin
            state      <= stateNext;
            shiftReg   <= shiftNext;
            bitCnt     <= cntNext;
            sampleReg  <= sampleNext;
            frameMode  <= frameModeNext;
            rampReg    <= rampNext;
            lfsrReg    <= lfsrNext;
            sdo        <= sdoNext;
            sdo_oe     <= oeNext;
            frame_done <= doneNext;
            frame_err  <= errNext;
            frame_cnt  <= frameCntNext;
            last_word  <= lastWordNext;
        end
    end

    always_comb begin
        stateNext     = state;
        shiftNext     = shiftReg;
        cntNext       = bitCnt;
        sampleNext    = sampleReg;
        frameModeNext = frameMode;
        rampNext      = rampReg;
        lfsrNext      = lfsrReg;
        sdoNext       = sdo;
        oeNext        = sdo_oe;
        doneNext      = 1'b0;
        errNext       = 1'b0;
        frameCntNext  = frame_cnt;
        lastWordNext  = last_word;

        case (state)
            IDLE: begin
                if (syncFall) begin
                    // Mode and value are frozen here so mid-frame config changes hit the next frame.
                    sampleNext    = pattern;
                    frameModeNext = mode;
                    shiftNext     = frameInit;
                    sdoNext       = frameInit[FRAME-1];
                    oeNext        = 1'b1;
                    cntNext       = '0;
                    stateNext     = SHIFT;
                end
            end
            SHIFT: begin
                // sync rise is checked first: a coincident sclk fall is discarded.
                if (syncRise) begin
                    errNext   = 1'b1;
                    sdoNext   = 1'b0;
                    oeNext    = 1'b0;
                    stateNext = IDLE;
                end else if (sclkFall) begin
                    cntNext = bitCnt + 1'b1;
                    if (bitCnt == CNT_W'(FRAME - 1)) begin
                        sdoNext      = 1'b0;
                        doneNext     = 1'b1;
                        lastWordNext = sampleReg;
                        frameCntNext = frame_cnt + 16'd1;
                        if (frameMode == MODE_RAMP) begin
                            rampNext = rampReg + ramp_step;
                        end else if (frameMode == MODE_LFSR) begin
                            lfsrNext = {lfsrReg[DATA_W-2:0], ^(lfsrReg & LFSR_TAPS)};
                        end
                        stateNext = DONE;
                    end else begin
                        shiftNext = {shiftReg[FRAME-2:0], 1'b0};
                        sdoNext   = shiftReg[FRAME-2];
                    end
                end
            end
            DONE: begin
                sdoNext = 1'b0;
                if (syncRise) begin
                    oeNext    = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: begin
                sdoNext   = 1'b0;
                oeNext    = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

endmodule
